// File: rtl/id_pipe.sv
// id_pipe: RV32I decode stage with forwarding, load-use stall and one output register.
// Ports: clk_in/rst_in, flush_in, in_* request, rf_* reads, fwd_* sources, out_* bundle, stall_cnt.

package id_pipe_pkg;
    typedef enum logic [5:0] {
        CMD_NOP   = 6'd0,
        CMD_LUI   = 6'd1,
        CMD_AUIPC = 6'd2,
        CMD_JAL   = 6'd3,
        CMD_JALR  = 6'd4,
        CMD_BEQ   = 6'd5,
        CMD_BNE   = 6'd6,
        CMD_BLT   = 6'd7,
        CMD_BGE   = 6'd8,
        CMD_BLTU  = 6'd9,
        CMD_BGEU  = 6'd10,
        CMD_LB    = 6'd11,
        CMD_LH    = 6'd12,
        CMD_LW    = 6'd13,
        CMD_LBU   = 6'd14,
        CMD_LHU   = 6'd15,
        CMD_SB    = 6'd16,
        CMD_SH    = 6'd17,
        CMD_SW    = 6'd18,
        CMD_ADDI  = 6'd19,
        CMD_SLTI  = 6'd20,
        CMD_SLTIU = 6'd21,
        CMD_XORI  = 6'd22,
        CMD_ORI   = 6'd23,
        CMD_ANDI  = 6'd24,
        CMD_SLLI  = 6'd25,
        CMD_SRLI  = 6'd26,
        CMD_SRAI  = 6'd27,
        CMD_ADD   = 6'd28,
        CMD_SUB   = 6'd29,
        CMD_SLL   = 6'd30,
        CMD_SLT   = 6'd31,
        CMD_SLTU  = 6'd32,
        CMD_XOR   = 6'd33,
        CMD_SRL   = 6'd34,
        CMD_SRA   = 6'd35,
        CMD_OR    = 6'd36,
        CMD_AND   = 6'd37
    } cmd_e;
endpackage

module id_pipe
    import id_pipe_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_FWD     = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    flush_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_pc,
    input  logic [31:0]             in_instr,
    output logic [4:0]              rf_rs1_addr,
    output logic [4:0]              rf_rs2_addr,
    input  logic [XLEN-1:0]         rf_rs1_data,
    input  logic [XLEN-1:0]         rf_rs2_data,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_is_load,
    input  logic [5*NUM_FWD-1:0]    fwd_addr,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_pc,
    output logic [XLEN-1:0]         out_op1,
    output logic [XLEN-1:0]         out_op2,
    output logic [XLEN-1:0]         out_imm,
    output logic [4:0]              out_rd,
    output logic                    out_wr_rd,
    output logic [5:0]              out_cmd,
    output logic                    out_illegal,
    output logic [STALL_CNT_W-1:0]  stall_cnt
);

    logic [6:0]        opc;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    cmd_e              cmd;
    logic              ill;
    logic              wr;
    logic              use1;
    logic              use2;
    logic              is_shift;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]   imm;
    logic              hit1, hit2, ld1, ld2;
    logic [XLEN-1:0]   fd1, fd2;
    logic [XLEN-1:0]   op1, op2;
    logic              hazard;
    logic              load;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];
    assign rs1 = in_instr[19:15];
    assign rs2 = in_instr[24:20];

    assign rf_rs1_addr = rs1;
    assign rf_rs2_addr = rs2;

    always_comb begin
        cmd      = CMD_NOP;
        ill      = 1'b0;
        wr       = 1'b0;
        use1     = 1'b0;
        use2     = 1'b0;
        is_shift = 1'b0;
        imm32    = '0;
        unique case (opc)
            7'b0110111: begin
                cmd   = CMD_LUI;
                wr    = 1'b1;
                imm32 = {in_instr[31:12], 12'b0};
            end
            7'b0010111: begin
                cmd   = CMD_AUIPC;
                wr    = 1'b1;
                imm32 = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                cmd   = CMD_JAL;
                wr    = 1'b1;
                imm32 = {{12{in_instr[31]}}, in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b1100111: begin
                cmd   = CMD_JALR;
                wr    = 1'b1;
                use1  = 1'b1;
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                ill   = (f3 != 3'd0);
            end
            7'b1100011: begin
                use1  = 1'b1;
                use2  = 1'b1;
                imm32 = {{20{in_instr[31]}}, in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
                case (f3)
                    3'd0:    cmd = CMD_BEQ;
                    3'd1:    cmd = CMD_BNE;
                    3'd4:    cmd = CMD_BLT;
                    3'd5:    cmd = CMD_BGE;
                    3'd6:    cmd = CMD_BLTU;
                    3'd7:    cmd = CMD_BGEU;
                    default: ill = 1'b1;
                endcase
            end
            7'b0000011: begin
                wr    = 1'b1;
                use1  = 1'b1;
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                case (f3)
                    3'd0:    cmd = CMD_LB;
                    3'd1:    cmd = CMD_LH;
                    3'd2:    cmd = CMD_LW;
                    3'd4:    cmd = CMD_LBU;
                    3'd5:    cmd = CMD_LHU;
                    default: ill = 1'b1;
                endcase
            end
            7'b0100011: begin
                use1  = 1'b1;
                use2  = 1'b1;
                imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                case (f3)
                    3'd0:    cmd = CMD_SB;
                    3'd1:    cmd = CMD_SH;
                    3'd2:    cmd = CMD_SW;
                    default: ill = 1'b1;
                endcase
            end
            7'b0010011: begin
                wr    = 1'b1;
                use1  = 1'b1;
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                case (f3)
                    3'd0: cmd = CMD_ADDI;
                    3'd2: cmd = CMD_SLTI;
                    3'd3: cmd = CMD_SLTIU;
                    3'd4: cmd = CMD_XORI;
                    3'd6: cmd = CMD_ORI;
                    3'd7: cmd = CMD_ANDI;
                    3'd1: begin
                        is_shift = 1'b1;
                        cmd      = CMD_SLLI;
                        ill      = (f7 != 7'b0000000);
                    end
                    default: begin
                        is_shift = 1'b1;
                        if (f7 == 7'b0000000)
                            cmd = CMD_SRLI;
                        else if (f7 == 7'b0100000)
                            cmd = CMD_SRAI;
                        else
                            ill = 1'b1;
                    end
                endcase
            end
            7'b0110011: begin
                wr   = 1'b1;
                use1 = 1'b1;
                use2 = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'd0:    cmd = CMD_ADD;
                        3'd1:    cmd = CMD_SLL;
                        3'd2:    cmd = CMD_SLT;
                        3'd3:    cmd = CMD_SLTU;
                        3'd4:    cmd = CMD_XOR;
                        3'd5:    cmd = CMD_SRL;
                        3'd6:    cmd = CMD_OR;
                        default: cmd = CMD_AND;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    case (f3)
                        3'd0:    cmd = CMD_SUB;
                        3'd5:    cmd = CMD_SRA;
                        default: ill = 1'b1;
                    endcase
                end else begin
                    ill = 1'b1;
                end
            end
            7'b0001111, 7'b1110011: begin
                cmd = CMD_NOP;
            end
            default: ill = 1'b1;
        endcase
        // Illegal words travel as inert bundles: no sources, no writeback.
        if (ill) begin
            cmd      = CMD_NOP;
            wr       = 1'b0;
            use1     = 1'b0;
            use2     = 1'b0;
            is_shift = 1'b0;
            imm32    = '0;
        end
    end

    assign imm = is_shift ? XLEN'(in_instr[24:20]) : XLEN'(imm32);

    // Scan oldest to youngest so the youngest matching slot wins.
    always_comb begin
        hit1 = 1'b0;
        ld1  = 1'b0;
        fd1  = '0;
        hit2 = 1'b0;
        ld2  = 1'b0;
        fd2  = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && fwd_addr[i*5 +: 5] == rs1) begin
                hit1 = 1'b1;
                ld1  = fwd_is_load[i];
                fd1  = fwd_data[i*XLEN +: XLEN];
            end
            if (fwd_valid[i] && fwd_addr[i*5 +: 5] == rs2) begin
                hit2 = 1'b1;
                ld2  = fwd_is_load[i];
                fd2  = fwd_data[i*XLEN +: XLEN];
            end
        end
    end

    assign op1 = (!use1 || rs1 == 5'd0) ? '0 : (hit1 ? fd1 : rf_rs1_data);
    assign op2 = (!use2 || rs2 == 5'd0) ? '0 : (hit2 ? fd2 : rf_rs2_data);

    assign hazard = (use1 && rs1 != 5'd0 && hit1 && ld1) ||
                    (use2 && rs2 != 5'd0 && hit2 && ld2);

    assign in_ready = !hazard && (!out_valid || out_ready) && !flush_in;
    assign load     = in_valid && in_ready;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_imm     <= '0;
            out_rd      <= '0;
            out_wr_rd   <= 1'b0;
            out_cmd     <= '0;
            out_illegal <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            if (flush_in) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid   <= 1'b1;
                out_pc      <= in_pc;
                out_op1     <= op1;
                out_op2     <= op2;
                out_imm     <= imm;
                out_rd      <= wr ? in_instr[11:7] : 5'd0;
                out_wr_rd   <= wr;
                out_cmd     <= cmd;
                out_illegal <= ill;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (in_valid && hazard && !flush_in && stall_cnt != '1)
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_pipe.sv
// Scoreboard bench for id_pipe: directed RV32I words, queue of expected bundles.
// Also checks reset, stall, back-pressure and flush behaviour directly.

module tb_id_pipe;

    localparam int XLEN = 32;
    localparam int NF   = 2;
    localparam int SW   = 16;

    localparam logic [5:0] C_NOP  = 6'd0;
    localparam logic [5:0] C_LUI  = 6'd1;
    localparam logic [5:0] C_JAL  = 6'd3;
    localparam logic [5:0] C_BEQ  = 6'd5;
    localparam logic [5:0] C_LW   = 6'd13;
    localparam logic [5:0] C_SW   = 6'd18;
    localparam logic [5:0] C_ADDI = 6'd19;
    localparam logic [5:0] C_SRAI = 6'd27;
    localparam logic [5:0] C_ADD  = 6'd28;
    localparam logic [5:0] C_SUB  = 6'd29;

    logic                 clk_in;
    logic                 rst_in;
    logic                 flush_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_pc;
    logic [31:0]          in_instr;
    logic [4:0]           rf_rs1_addr;
    logic [4:0]           rf_rs2_addr;
    logic [XLEN-1:0]      rf_rs1_data;
    logic [XLEN-1:0]      rf_rs2_data;
    logic [NF-1:0]        fwd_valid;
    logic [NF-1:0]        fwd_is_load;
    logic [5*NF-1:0]      fwd_addr;
    logic [XLEN*NF-1:0]   fwd_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_pc;
    logic [XLEN-1:0]      out_op1;
    logic [XLEN-1:0]      out_op2;
    logic [XLEN-1:0]      out_imm;
    logic [4:0]           out_rd;
    logic                 out_wr_rd;
    logic [5:0]           out_cmd;
    logic                 out_illegal;
    logic [SW-1:0]        stall_cnt;

    id_pipe #(.XLEN(XLEN), .NUM_FWD(NF), .STALL_CNT_W(SW)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .flush_in    (flush_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .rf_rs1_addr (rf_rs1_addr),
        .rf_rs2_addr (rf_rs2_addr),
        .rf_rs1_data (rf_rs1_data),
        .rf_rs2_data (rf_rs2_data),
        .fwd_valid   (fwd_valid),
        .fwd_is_load (fwd_is_load),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_op1     (out_op1),
        .out_op2     (out_op2),
        .out_imm     (out_imm),
        .out_rd      (out_rd),
        .out_wr_rd   (out_wr_rd),
        .out_cmd     (out_cmd),
        .out_illegal (out_illegal),
        .stall_cnt   (stall_cnt)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wr;
        logic [5:0]  cmd;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] op1,
                                input logic [31:0] op2, input logic [31:0] imm,
                                input logic [4:0] rd, input logic wr,
                                input logic [5:0] cmd, input logic ill);
        exp_t e;
        e.pc  = pc;
        e.op1 = op1;
        e.op2 = op2;
        e.imm = imm;
        e.rd  = rd;
        e.wr  = wr;
        e.cmd = cmd;
        e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string name, input logic [159:0] act,
                       input logic [159:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic set_fwd(input int i, input logic v, input logic [4:0] a,
                           input logic [31:0] d, input logic ld);
        fwd_valid[i]          = v;
        fwd_addr[i*5 +: 5]    = a;
        fwd_data[i*XLEN +: XLEN] = d;
        fwd_is_load[i]        = ld;
    endtask

    task automatic clr_fwd();
        fwd_valid   = '0;
        fwd_is_load = '0;
        fwd_addr    = '0;
        fwd_data    = '0;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [31:0] ins, input exp_t e, input bit push);
        int n;
        in_instr = ins;
        in_pc    = e.pc;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk_in);
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk_in);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout pc=%h: in_ready stuck at 0", e.pc);
        end else if (push) begin
            q.push_back(e);
        end
        @(posedge clk_in);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (2) @(posedge clk_in);
        #1;
    endtask

    always @(negedge clk_in) begin
        exp_t a;
        exp_t e;
        if (rst_in && out_valid && out_ready) begin
            a = {out_pc, out_op1, out_op2, out_imm, out_rd,
                 out_wr_rd, out_cmd, out_illegal};
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL bundle_unexpected: got pc=%h cmd=%0d, want none",
                         out_pc, out_cmd);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    failures++;
                    $display("FAIL bundle pc=%h: got %h want %h", e.pc, a, e);
                end
            end
        end
    end

    initial begin
        rst_in      = 1'b0;
        flush_in    = 1'b0;
        in_valid    = 1'b0;
        in_pc       = '0;
        in_instr    = '0;
        rf_rs1_data = '0;
        rf_rs2_data = '0;
        out_ready   = 1'b1;
        clr_fwd();

        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_valid", 160'(out_valid), 160'(0));
        chk("rst_stall", 160'(stall_cnt), 160'(0));
        chk("rst_bundle", 160'({out_pc, out_op1, out_op2, out_imm, out_rd,
                                out_wr_rd, out_cmd, out_illegal}), 160'(0));
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;

        rf_rs1_data = 32'hDEADBEEF;
        rf_rs2_data = 32'h12345678;
        in_instr    = 32'h00500093;
        #1;
        chk("rs1_addr", 160'(rf_rs1_addr), 160'(0));
        chk("rs2_addr", 160'(rf_rs2_addr), 160'(5));
        issue(32'h00500093, mk(32'h100, 0, 0, 5, 1, 1, C_ADDI, 0), 1);

        set_fwd(0, 1'b1, 5'd1, 32'd7, 1'b0);
        set_fwd(1, 1'b1, 5'd1, 32'd9, 1'b0);
        rf_rs1_data = 32'h111;
        rf_rs2_data = 32'd4;
        issue(32'h002081B3, mk(32'h104, 7, 4, 0, 3, 1, C_ADD, 0), 1);
        issue(32'h402081B3, mk(32'h108, 7, 4, 0, 3, 1, C_SUB, 0), 1);
        set_fwd(0, 1'b0, 5'd1, 32'd7, 1'b0);
        issue(32'h002081B3, mk(32'h10C, 9, 4, 0, 3, 1, C_ADD, 0), 1);
        clr_fwd();
        issue(32'h002081B3, mk(32'h110, 32'h111, 4, 0, 3, 1, C_ADD, 0), 1);

        rf_rs1_data = 32'h100;
        issue(32'h0000A283, mk(32'h114, 32'h100, 0, 0, 5, 1, C_LW, 0), 1);

        set_fwd(0, 1'b1, 5'd5, 32'h99, 1'b1);
        rf_rs1_data = 32'h77;
        in_instr    = 32'h00028333;
        in_pc       = 32'h118;
        in_valid    = 1'b1;
        @(negedge clk_in);
        chk("lu_ready_c1", 160'(in_ready), 160'(0));
        @(negedge clk_in);
        chk("lu_ready_c2", 160'(in_ready), 160'(0));
        @(posedge clk_in);
        #1;
        set_fwd(0, 1'b1, 5'd5, 32'h55, 1'b0);
        @(negedge clk_in);
        chk("lu_stall_cnt", 160'(stall_cnt), 160'(2));
        chk("lu_ready_after", 160'(in_ready), 160'(1));
        if (in_ready)
            q.push_back(mk(32'h118, 32'h55, 0, 0, 6, 1, C_ADD, 0));
        @(posedge clk_in);
        #1;
        in_valid = 1'b0;
        clr_fwd();

        rf_rs1_data = 32'hA;
        rf_rs2_data = 32'hB;
        issue(32'hFE208CE3, mk(32'h11C, 32'hA, 32'hB, 32'hFFFFFFF8, 0, 0, C_BEQ, 0), 1);
        issue(32'h0020A623, mk(32'h120, 32'hA, 32'hB, 12, 0, 0, C_SW, 0), 1);
        issue(32'h4030D213, mk(32'h124, 32'hA, 0, 3, 4, 1, C_SRAI, 0), 1);
        issue(32'hFFDFF0EF, mk(32'h128, 0, 0, 32'hFFFFFFFC, 1, 1, C_JAL, 0), 1);
        issue(32'h00000073, mk(32'h12C, 0, 0, 0, 0, 0, C_NOP, 0), 1);
        issue(32'h0000007F, mk(32'h130, 0, 0, 0, 0, 0, C_NOP, 1), 1);
        issue(32'h022081B3, mk(32'h134, 0, 0, 0, 0, 0, C_NOP, 1), 1);
        drain();

        out_ready = 1'b0;
        issue(32'hFFF00393, mk(32'h138, 0, 0, 32'hFFFFFFFF, 7, 1, C_ADDI, 0), 1);
        in_instr = 32'h12345437;
        in_pc    = 32'h13C;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            chk("bp_valid", 160'(out_valid), 160'(1));
            chk("bp_hold", 160'({out_pc, out_imm, out_rd, out_cmd}),
                160'({32'h138, 32'hFFFFFFFF, 5'd7, C_ADDI}));
            chk("bp_ready", 160'(in_ready), 160'(0));
        end
        @(posedge clk_in);
        #1;
        out_ready = 1'b1;
        issue(32'h12345437, mk(32'h13C, 0, 0, 32'h12345000, 8, 1, C_LUI, 0), 1);
        drain();

        out_ready = 1'b0;
        issue(32'h00500093, mk(32'h140, 0, 0, 5, 1, 1, C_ADDI, 0), 0);
        flush_in = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00028333;
        in_pc    = 32'h144;
        set_fwd(0, 1'b1, 5'd5, 32'h0, 1'b1);
        @(negedge clk_in);
        chk("fl1_ready", 160'(in_ready), 160'(0));
        @(posedge clk_in);
        #1;
        flush_in = 1'b0;
        in_valid = 1'b0;
        clr_fwd();
        @(negedge clk_in);
        chk("fl1_valid", 160'(out_valid), 160'(0));
        chk("fl1_stall", 160'(stall_cnt), 160'(2));

        @(posedge clk_in);
        #1;
        out_ready = 1'b1;
        flush_in  = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h00500093;
        in_pc     = 32'h148;
        @(negedge clk_in);
        chk("fl2_ready", 160'(in_ready), 160'(0));
        @(posedge clk_in);
        #1;
        flush_in = 1'b0;
        in_valid = 1'b0;
        @(negedge clk_in);
        chk("fl2_valid", 160'(out_valid), 160'(0));
        @(posedge clk_in);
        #1;

        out_ready = 1'b0;
        issue(32'h0000007F, mk(32'h14C, 0, 0, 0, 0, 0, C_NOP, 1), 0);
        @(negedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        chk("mid_rst_valid", 160'(out_valid), 160'(0));
        chk("mid_rst_bundle", 160'({out_pc, out_op1, out_op2, out_imm, out_rd,
                                    out_wr_rd, out_cmd, out_illegal, stall_cnt}),
            160'(0));
        @(posedge clk_in);
        #1;
        rst_in    = 1'b1;
        out_ready = 1'b1;
        in_instr  = 32'h00500093;
        in_pc     = 32'h150;
        in_valid  = 1'b1;
        #1;
        chk("rel_ready", 160'(in_ready), 160'(1));
        issue(32'h00500093, mk(32'h150, 0, 0, 5, 1, 1, C_ADDI, 0), 1);
        drain();

        chk("queue_empty", 160'(q.size()), 160'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
